// File: rtl/sc_level_progress.sv
// Level progress tracker: counts scroll ticks in the START state and pulses LevelUp (active low) or Finish at the per-level threshold.
// Optional feature: define SC_LEVELPROGRESS_CRASH_PENALTY_EN to subtract PENALTY_ROWS on each rising crash edge.
module sc_level_progress #(
  parameter int unsigned DIST_W       = 10,
  parameter int unsigned BASE_ROWS    = 64,
  parameter int unsigned STEP_ROWS    = 16,
  parameter int unsigned MAX_LEVEL    = 5,
  parameter int unsigned SETTLE_CYC   = 8,
  parameter int unsigned PENALTY_ROWS = 8
) (
  input  logic              SC_LEVELPROGRESS_CLOCK_50,
  input  logic              SC_LEVELPROGRESS_RESET_InHigh,
  input  logic [1:0]        SC_LEVELPROGRESS_CurrentState_InBus,
  input  logic              SC_LEVELPROGRESS_ScrollTick_InHigh,
  input  logic              SC_LEVELPROGRESS_Crash_InHigh,
  input  logic [2:0]        SC_LEVELPROGRESS_Level_InBus,
  output logic              SC_LEVELPROGRESS_LevelUp_OutLow,
  output logic              SC_LEVELPROGRESS_Finish_OutHigh,
  output logic [DIST_W-1:0] SC_LEVELPROGRESS_Progress_OutBus
);

  localparam int unsigned TW = DIST_W + 3;
  localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
  localparam logic [1:0]    GAME_START  = 2'd1;
  localparam logic [2:0]    MAX_LVL     = 3'(MAX_LEVEL);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] DIST_MAX    = {3'b000, {DIST_W{1'b1}}};

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PULSE, S_SETTLE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic              levelup_q, levelup_d;
  logic              finish_q, finish_d;
  logic [2:0]        lvl_q, lvl_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [TW-1:0]     thr_wide, thr_sat, dist_inc;

  // Threshold grows with level; saturate so it always fits the progress bus.
  always_comb begin
    thr_wide = TW'(BASE_ROWS) + TW'(SC_LEVELPROGRESS_Level_InBus) * TW'(STEP_ROWS);
    thr_sat  = (thr_wide > DIST_MAX) ? DIST_MAX : thr_wide;
    dist_inc = TW'(dist_q) + TW'(1);
  end

`ifdef SC_LEVELPROGRESS_CRASH_PENALTY_EN
  logic crash_prev_q;
  always_ff @(posedge SC_LEVELPROGRESS_CLOCK_50) begin
    if (SC_LEVELPROGRESS_RESET_InHigh) crash_prev_q <= 1'b0;
    else                               crash_prev_q <= SC_LEVELPROGRESS_Crash_InHigh;
  end
`endif

  always_comb begin
    state_d   = state_q;
    dist_d    = dist_q;
    levelup_d = 1'b1;
    finish_d  = 1'b0;
    lvl_d     = lvl_q;
    settle_d  = settle_q;
    // Leaving START overrides every state, including mid-pulse and settle.
    if (SC_LEVELPROGRESS_CurrentState_InBus != GAME_START) begin
      state_d  = S_IDLE;
      dist_d   = '0;
      settle_d = '0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_RUN;
        S_RUN: begin
          if (SC_LEVELPROGRESS_Crash_InHigh) begin
`ifdef SC_LEVELPROGRESS_CRASH_PENALTY_EN
            if (!crash_prev_q)
              dist_d = (dist_q > DIST_W'(PENALTY_ROWS)) ? dist_q - DIST_W'(PENALTY_ROWS) : '0;
`endif
          end else if (SC_LEVELPROGRESS_ScrollTick_InHigh) begin
            if (dist_inc >= thr_sat) begin
              dist_d = thr_sat[DIST_W-1:0];
              if (SC_LEVELPROGRESS_Level_InBus < MAX_LVL) begin
                lvl_d     = SC_LEVELPROGRESS_Level_InBus;
                levelup_d = 1'b0;
                state_d   = S_PULSE;
              end else begin
                finish_d = 1'b1;
                state_d  = S_DONE;
              end
            end else begin
              dist_d = dist_inc[DIST_W-1:0];
            end
          end
        end
        S_PULSE: begin
          settle_d = '0;
          state_d  = S_SETTLE;
        end
        S_SETTLE: begin
          // Wait for the level counter to move on, but never longer than SETTLE_CYC.
          if ((SC_LEVELPROGRESS_Level_InBus != lvl_q) || (settle_q == SETTLE_LAST)) begin
            dist_d   = '0;
            settle_d = '0;
            state_d  = S_RUN;
          end else begin
            settle_d = settle_q + SW'(1);
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge SC_LEVELPROGRESS_CLOCK_50) begin
    if (SC_LEVELPROGRESS_RESET_InHigh) begin
      state_q   <= S_IDLE;
      dist_q    <= '0;
      levelup_q <= 1'b1;
      finish_q  <= 1'b0;
      lvl_q     <= '0;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      dist_q    <= dist_d;
      levelup_q <= levelup_d;
      finish_q  <= finish_d;
      lvl_q     <= lvl_d;
      settle_q  <= settle_d;
    end
  end

  assign SC_LEVELPROGRESS_LevelUp_OutLow  = levelup_q;
  assign SC_LEVELPROGRESS_Finish_OutHigh  = finish_q;
  assign SC_LEVELPROGRESS_Progress_OutBus = dist_q;

endmodule

// File: tb/tb_sc_level_progress.sv
// Directed bench for sc_level_progress: threshold pulses, settle exit/timeout, finish, crash and abort paths.
module tb_sc_level_progress;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cur;
  logic       tick;
  logic       crash;
  logic [2:0] level;
  logic       lu;
  logic       fin;
  logic [9:0] prog;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sc_level_progress dut (
    .SC_LEVELPROGRESS_CLOCK_50          (clk),
    .SC_LEVELPROGRESS_RESET_InHigh      (rst),
    .SC_LEVELPROGRESS_CurrentState_InBus(cur),
    .SC_LEVELPROGRESS_ScrollTick_InHigh (tick),
    .SC_LEVELPROGRESS_Crash_InHigh      (crash),
    .SC_LEVELPROGRESS_Level_InBus       (level),
    .SC_LEVELPROGRESS_LevelUp_OutLow    (lu),
    .SC_LEVELPROGRESS_Finish_OutHigh    (fin),
    .SC_LEVELPROGRESS_Progress_OutBus   (prog)
  );

  // One clock: apply inputs, take the edge, outputs are sampled 1 time unit later.
  task automatic step(input logic tk, input logic cr);
    tick  = tk;
    crash = cr;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; cur = 2'd1; level = 3'd0;
    step(1'b0, 1'b0);
    checks++; if (prog !== 10'd0) begin errors++; $display("FAIL reset_prog got=%0d exp=0", prog); end
    checks++; if (lu !== 1'b1) begin errors++; $display("FAIL reset_levelup got=%b exp=1", lu); end
    checks++; if (fin !== 1'b0) begin errors++; $display("FAIL reset_finish got=%b exp=0", fin); end
    rst = 1'b0;
    step(1'b0, 1'b0);
  endtask

  task automatic test_level0_timeout;
    for (int k = 1; k <= 64; k++) begin
      step(1'b1, 1'b0);
      checks++; if (prog !== 10'(k)) begin errors++; $display("FAIL l0_prog k=%0d got=%0d exp=%0d", k, prog, k); end
      checks++; if (lu !== (k == 64 ? 1'b0 : 1'b1)) begin errors++; $display("FAIL l0_levelup k=%0d got=%b", k, lu); end
    end
    step(1'b1, 1'b0);
    checks++; if (lu !== 1'b1) begin errors++; $display("FAIL pulse_width got=%b exp=1", lu); end
    checks++; if (prog !== 10'd64) begin errors++; $display("FAIL settle_entry_prog got=%0d exp=64", prog); end
    for (int k = 0; k < 7; k++) begin
      step(1'b1, 1'b0);
      checks++; if (prog !== 10'd64) begin errors++; $display("FAIL settle_hold k=%0d got=%0d exp=64", k, prog); end
    end
    step(1'b0, 1'b0);
    checks++; if (prog !== 10'd0) begin errors++; $display("FAIL settle_timeout_prog got=%0d exp=0", prog); end
    step(1'b0, 1'b0);
    checks++; if (lu !== 1'b1) begin errors++; $display("FAIL no_second_pulse got=%b exp=1", lu); end
  endtask

  task automatic test_level_change;
    for (int k = 1; k <= 64; k++) step(1'b1, 1'b0);
    checks++; if (lu !== 1'b0) begin errors++; $display("FAIL lc_pulse got=%b exp=0", lu); end
    step(1'b0, 1'b0);
    level = 3'd1;
    step(1'b0, 1'b0);
    checks++; if (prog !== 10'd0) begin errors++; $display("FAIL lc_exit_prog got=%0d exp=0", prog); end
    for (int k = 1; k <= 80; k++) begin
      step(1'b1, 1'b0);
      checks++; if (prog !== 10'(k)) begin errors++; $display("FAIL l1_prog k=%0d got=%0d exp=%0d", k, prog, k); end
      checks++; if (lu !== (k == 80 ? 1'b0 : 1'b1)) begin errors++; $display("FAIL l1_levelup k=%0d got=%b", k, lu); end
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_finish;
    cur = 2'd0;
    step(1'b0, 1'b0);
    checks++; if (prog !== 10'd0) begin errors++; $display("FAIL abort_settle_prog got=%0d exp=0", prog); end
    cur = 2'd1; level = 3'd5;
    step(1'b0, 1'b0);
    for (int k = 1; k <= 144; k++) begin
      step(1'b1, 1'b0);
      checks++; if (prog !== 10'(k)) begin errors++; $display("FAIL l5_prog k=%0d got=%0d exp=%0d", k, prog, k); end
      checks++; if (fin !== (k == 144 ? 1'b1 : 1'b0)) begin errors++; $display("FAIL l5_finish k=%0d got=%b", k, fin); end
      checks++; if (lu !== 1'b1) begin errors++; $display("FAIL l5_levelup k=%0d got=%b exp=1", k, lu); end
    end
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0);
      checks++; if (prog !== 10'd144) begin errors++; $display("FAIL done_prog k=%0d got=%0d exp=144", k, prog); end
      checks++; if (fin !== 1'b0) begin errors++; $display("FAIL done_finish k=%0d got=%b exp=0", k, fin); end
    end
    cur = 2'd0;
    step(1'b0, 1'b0);
    checks++; if (prog !== 10'd0) begin errors++; $display("FAIL done_exit_prog got=%0d exp=0", prog); end
  endtask

  task automatic test_crash;
    logic [9:0] exp_p;
`ifdef SC_LEVELPROGRESS_CRASH_PENALTY_EN
    exp_p = 10'd0;
`else
    exp_p = 10'd5;
`endif
    cur = 2'd1; level = 3'd0;
    step(1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
    checks++; if (prog !== 10'd5) begin errors++; $display("FAIL crash_pre got=%0d exp=5", prog); end
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1);
      checks++; if (prog !== exp_p) begin errors++; $display("FAIL crash_tick k=%0d got=%0d exp=%0d", k, prog, exp_p); end
    end
    step(1'b1, 1'b0);
    checks++; if (prog !== exp_p + 10'd1) begin errors++; $display("FAIL crash_release got=%0d exp=%0d", prog, exp_p + 10'd1); end
  endtask

  task automatic test_abort;
    cur = 2'd0; step(1'b0, 1'b0);
    cur = 2'd1; step(1'b0, 1'b0);
    for (int k = 0; k < 64; k++) step(1'b1, 1'b0);
    checks++; if (lu !== 1'b0) begin errors++; $display("FAIL abort_pulse_setup got=%b exp=0", lu); end
    cur = 2'd0;
    step(1'b0, 1'b0);
    checks++; if (prog !== 10'd0) begin errors++; $display("FAIL abort_pulse_prog got=%0d exp=0", prog); end
    checks++; if (lu !== 1'b1) begin errors++; $display("FAIL abort_pulse_levelup got=%b exp=1", lu); end
    checks++; if (fin !== 1'b0) begin errors++; $display("FAIL abort_pulse_finish got=%b exp=0", fin); end
    cur = 2'd1; step(1'b0, 1'b0);
    for (int k = 0; k < 64; k++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    cur = 2'd2;
    step(1'b0, 1'b0);
    checks++; if (prog !== 10'd0) begin errors++; $display("FAIL abort_settle_prog2 got=%0d exp=0", prog); end
    checks++; if (lu !== 1'b1) begin errors++; $display("FAIL abort_settle_levelup got=%b exp=1", lu); end
    cur = 2'd1; step(1'b0, 1'b0);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0);
    checks++; if (prog !== 10'd10) begin errors++; $display("FAIL run_pre_reset got=%0d exp=10", prog); end
    rst = 1'b1;
    step(1'b1, 1'b0);
    checks++; if (prog !== 10'd0) begin errors++; $display("FAIL midrun_reset_prog got=%0d exp=0", prog); end
    checks++; if (lu !== 1'b1) begin errors++; $display("FAIL midrun_reset_levelup got=%b exp=1", lu); end
    rst = 1'b0;
    step(1'b1, 1'b0);
    checks++; if (prog !== 10'd0) begin errors++; $display("FAIL idle_tick_ignored got=%0d exp=0", prog); end
    step(1'b1, 1'b0);
    checks++; if (prog !== 10'd1) begin errors++; $display("FAIL rerun_first_tick got=%0d exp=1", prog); end
  endtask

  initial begin
    rst = 1'b1; cur = 2'd0; tick = 1'b0; crash = 1'b0; level = 3'd0;
    test_reset();
    test_level0_timeout();
    test_level_change();
    test_finish();
    test_crash();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
